// File: rtl/ca_multicycle_core.sv
// Multi-cycle RV32I-subset core: FETCH/DECODE/EXECUTE/WRITEBACK with writable
// program memory, BEQ/BNE branches, ECALL halt and an illegal-opcode trap.
module ca_multicycle_core #(
  parameter int PROG_AW   = 5,
  parameter int NREG_LOG2 = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               prog_we,
  input  logic [PROG_AW-1:0] prog_addr,
  input  logic [31:0]        prog_wdata,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [PROG_AW-1:0] pc,
  output logic [31:0]        out_value,
  output logic [15:0]        retired
);

  localparam int DATA_W = 32;
  localparam int NREG   = 1 << NREG_LOG2;
  localparam int DEPTH  = 1 << PROG_AW;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_DECODE    = 3'd2;
  localparam logic [2:0] S_EXECUTE   = 3'd3;
  localparam logic [2:0] S_WRITEBACK = 3'd4;
  localparam logic [2:0] S_HALT      = 3'd5;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_SYS = 7'b1110011;

  logic [2:0]               state;
  logic [DATA_W-1:0]        mem  [DEPTH];
  logic [DATA_W-1:0]        regs [NREG];

  logic [31:0]              ir_p0;
  logic signed [DATA_W-1:0] op1_p1;
  logic signed [DATA_W-1:0] op2_p1;
  logic signed [DATA_W-1:0] imm_p1;
  logic [DATA_W-1:0]        result_p2;
  logic                     taken_p2;
  logic                     wr_en_p2;

  logic [6:0]               opcode;
  logic [2:0]               funct3;
  logic                     funct7_b5;
  logic [NREG_LOG2-1:0]     rd_idx;
  logic [NREG_LOG2-1:0]     rs1_idx;
  logic [NREG_LOG2-1:0]     rs2_idx;
  logic signed [DATA_W-1:0] imm_dec;
  logic [4:0]               shamt;
  logic [PROG_AW-1:0]       br_off;

  logic [DATA_W-1:0]        alu_res;
  logic                     alu_wr;
  logic                     alu_taken;
  logic                     alu_ill;
  logic                     is_ecall;

  assign busy = (state == S_FETCH) || (state == S_DECODE) ||
                (state == S_EXECUTE) || (state == S_WRITEBACK);
  assign done = (state == S_HALT);

  // Upper index bits are dropped so small register files alias.
  assign opcode    = ir_p0[6:0];
  assign funct3    = ir_p0[14:12];
  assign funct7_b5 = ir_p0[30];
  assign rd_idx    = ir_p0[7 +: NREG_LOG2];
  assign rs1_idx   = ir_p0[15 +: NREG_LOG2];
  assign rs2_idx   = ir_p0[20 +: NREG_LOG2];
  assign shamt     = op2_p1[4:0];
  assign br_off    = imm_p1[PROG_AW+1:2];

  always_comb begin
    case (opcode)
      OP_BR:   imm_dec = {{19{ir_p0[31]}}, ir_p0[31], ir_p0[7], ir_p0[30:25], ir_p0[11:8], 1'b0};
      OP_LUI:  imm_dec = {ir_p0[31:12], 12'b0};
      default: imm_dec = {{20{ir_p0[31]}}, ir_p0[31:20]};
    endcase
  end

  always_comb begin
    alu_res   = '0;
    alu_wr    = 1'b0;
    alu_taken = 1'b0;
    alu_ill   = 1'b0;
    is_ecall  = 1'b0;
    case (opcode)
      OP_R: begin
        alu_wr = 1'b1;
        case (funct3)
          3'b000: begin
            if (funct7_b5) alu_res = op1_p1 - op2_p1;
            else           alu_res = op1_p1 + op2_p1;
          end
          3'b001: alu_res = op1_p1 << shamt;
          3'b010: alu_res = {{(DATA_W-1){1'b0}}, op1_p1 < op2_p1};
          3'b100: alu_res = op1_p1 ^ op2_p1;
          3'b101: begin
            if (funct7_b5) alu_res = op1_p1 >>> shamt;
            else           alu_res = $unsigned(op1_p1) >> shamt;
          end
          3'b110: alu_res = op1_p1 | op2_p1;
          3'b111: alu_res = op1_p1 & op2_p1;
          default: begin
            alu_wr  = 1'b0;
            alu_ill = 1'b1;
          end
        endcase
      end
      OP_I: begin
        alu_wr = 1'b1;
        case (funct3)
          3'b000: alu_res = op1_p1 + imm_p1;
          3'b010: alu_res = {{(DATA_W-1){1'b0}}, op1_p1 < imm_p1};
          3'b100: alu_res = op1_p1 ^ imm_p1;
          3'b110: alu_res = op1_p1 | imm_p1;
          3'b111: alu_res = op1_p1 & imm_p1;
          default: begin
            alu_wr  = 1'b0;
            alu_ill = 1'b1;
          end
        endcase
      end
      OP_LUI: begin
        alu_wr  = 1'b1;
        alu_res = imm_p1;
      end
      OP_BR: begin
        case (funct3)
          3'b000:  alu_taken = (op1_p1 == op2_p1);
          3'b001:  alu_taken = (op1_p1 != op2_p1);
          default: alu_ill   = 1'b1;
        endcase
      end
      OP_SYS:  is_ecall = 1'b1;
      default: alu_ill  = 1'b1;
    endcase
  end

  // Start cycle is not busy, so a coincident write lands before the first fetch.
  always_ff @(posedge clk) begin
    if (prog_we && !busy) mem[prog_addr] <= prog_wdata;
  end

  // Stage registers: fetch -> p0, decode -> p1, execute -> p2
  always_ff @(posedge clk) begin
    if (state == S_FETCH) ir_p0 <= mem[pc];
    if (state == S_DECODE) begin
      op1_p1 <= regs[rs1_idx];
      op2_p1 <= regs[rs2_idx];
      imm_p1 <= imm_dec;
    end
    if (state == S_EXECUTE) begin
      result_p2 <= alu_res;
      taken_p2  <= alu_taken;
      wr_en_p2  <= alu_wr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (state == S_WRITEBACK && wr_en_p2 && rd_idx != '0) begin
      regs[rd_idx] <= result_p2;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      pc        <= '0;
      error     <= 1'b0;
      out_value <= '0;
      retired   <= '0;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            state   <= S_FETCH;
            pc      <= '0;
            retired <= '0;
            error   <= 1'b0;
          end
        end
        S_FETCH:  state <= S_DECODE;
        S_DECODE: state <= S_EXECUTE;
        S_EXECUTE: begin
          if (is_ecall) begin
            state <= S_HALT;
          end else if (alu_ill) begin
            state <= S_HALT;
            error <= 1'b1;
          end else begin
            state <= S_WRITEBACK;
          end
        end
        S_WRITEBACK: begin
          if (wr_en_p2 && rd_idx != '0) out_value <= result_p2;
          retired <= retired + 16'd1;
          pc      <= taken_p2 ? pc + br_off : pc + 1'b1;
          state   <= S_FETCH;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ca_multicycle_core.sv
// Scoreboarded bench for ca_multicycle_core: directed programs plus random
// straight-line/forward-branch programs checked against an ISA-level model.
module tb_ca_multicycle_core;

  localparam logic [31:0] ECALL = 32'h0000_0073;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        prog_we;
  logic [4:0]  prog_addr;
  logic [31:0] prog_wdata;
  logic        busy, done, error;
  logic [4:0]  pc;
  logic [31:0] out_value;
  logic [15:0] retired;

  logic        s_start, s_we;
  logic [2:0]  s_addr;
  logic [31:0] s_wdata;
  logic        s_busy, s_done, s_error;
  logic [2:0]  s_pc;
  logic [31:0] s_out;
  logic [15:0] s_ret;

  ca_multicycle_core #(.PROG_AW(5), .NREG_LOG2(5)) dut (
    .clk(clk), .reset(reset), .start(start), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_wdata(prog_wdata), .busy(busy), .done(done),
    .error(error), .pc(pc), .out_value(out_value), .retired(retired)
  );

  ca_multicycle_core #(.PROG_AW(3), .NREG_LOG2(4)) dut_small (
    .clk(clk), .reset(reset), .start(s_start), .prog_we(s_we),
    .prog_addr(s_addr), .prog_wdata(s_wdata), .busy(s_busy), .done(s_done),
    .error(s_error), .pc(s_pc), .out_value(s_out), .retired(s_ret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] outv;
    logic [15:0] ret;
    logic [4:0]  pc;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_mem  [32];
  logic [31:0] m_regs [32];
  logic [31:0] m_out;
  logic [31:0] prog_q[$];

  function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
    logic [6:0] a = f7[6:0];
    logic [4:0] b = rs2[4:0];
    logic [4:0] c = rs1[4:0];
    logic [2:0] d = f3[2:0];
    logic [4:0] e = rd[4:0];
    return {a, b, c, d, e, 7'h33};
  endfunction

  function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd);
    logic [11:0] a = imm[11:0];
    logic [4:0]  c = rs1[4:0];
    logic [2:0]  d = f3[2:0];
    logic [4:0]  e = rd[4:0];
    return {a, c, d, e, 7'h13};
  endfunction

  function automatic logic [31:0] enc_u(int imm20, int rd);
    logic [19:0] a = imm20[19:0];
    logic [4:0]  e = rd[4:0];
    return {a, e, 7'h37};
  endfunction

  function automatic logic [31:0] enc_b(int off, int rs2, int rs1, int f3);
    logic [12:0] im = off[12:0];
    logic [4:0]  b = rs2[4:0];
    logic [4:0]  c = rs1[4:0];
    logic [2:0]  d = f3[2:0];
    return {im[12], im[10:5], b, c, d, im[4:1], im[11], 7'h63};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic summary_and_finish();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  task automatic bail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s actual=no completion required=completion", nm);
    summary_and_finish();
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_out = 32'd0;
  endtask

  // Instruction-set level interpretation of the program in m_mem.
  task automatic run_model(output exp_t e);
    logic [4:0]  mpc = 5'd0;
    int          ret = 0;
    int          steps = 0;
    bit          fin = 0;
    logic [31:0] ins, a, b, res;
    int          immi, boff;
    bit          wr, tk, ill;
    e.err = 1'b0;
    while (!fin && steps < 4000) begin
      steps++;
      ins  = m_mem[mpc];
      a    = (ins[19:15] == 5'd0) ? 32'd0 : m_regs[ins[19:15]];
      b    = (ins[24:20] == 5'd0) ? 32'd0 : m_regs[ins[24:20]];
      immi = int'($signed(ins[31:20]));
      boff = int'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      wr = 0; tk = 0; ill = 0; res = 32'd0;
      case (ins[6:0])
        7'b1110011: fin = 1;
        7'b0110011: begin
          wr = 1;
          case (ins[14:12])
            3'd0: res = ins[30] ? a - b : a + b;
            3'd1: res = a << b[4:0];
            3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd4: res = a ^ b;
            3'd5: res = ins[30] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6: res = a | b;
            3'd7: res = a & b;
            default: ill = 1;
          endcase
        end
        7'b0010011: begin
          wr = 1;
          case (ins[14:12])
            3'd0: res = a + 32'(immi);
            3'd2: res = ($signed(a) < immi) ? 32'd1 : 32'd0;
            3'd4: res = a ^ 32'(immi);
            3'd6: res = a | 32'(immi);
            3'd7: res = a & 32'(immi);
            default: ill = 1;
          endcase
        end
        7'b0110111: begin wr = 1; res = {ins[31:12], 12'd0}; end
        7'b1100011: begin
          if (ins[14:12] == 3'd0)      tk = (a == b);
          else if (ins[14:12] == 3'd1) tk = (a != b);
          else                         ill = 1;
        end
        default: ill = 1;
      endcase
      if (ill) begin
        fin = 1;
        e.err = 1'b1;
      end else if (!fin) begin
        if (wr && ins[11:7] != 5'd0) begin
          m_regs[ins[11:7]] = res;
          m_out = res;
        end
        ret++;
        if (tk) mpc = 5'(int'(mpc) + (boff >>> 2));
        else    mpc = mpc + 5'd1;
      end
    end
    e.outv = m_out;
    e.ret  = ret[15:0];
    e.pc   = mpc;
    e.cyc  = 4 * ret + 3;
  endtask

  // Scoreboard monitor: compares on each rising edge of done.
  logic busy_q = 1'b0;
  logic done_q = 1'b0;
  int   cyc = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      busy_q = 1'b0;
      done_q = 1'b0;
      cyc    = 0;
    end else begin
      if (busy && !busy_q) cyc = 1;
      else if (busy)       cyc++;
      if (done && !done_q) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=halted required=no run pending");
        end else begin
          e = exp_q.pop_front();
          chk("sb_out_value", out_value, e.outv);
          chk("sb_retired", {16'd0, retired}, {16'd0, e.ret});
          chk("sb_pc", {27'd0, pc}, {27'd0, e.pc});
          chk("sb_error", {31'd0, error}, {31'd0, e.err});
          chk("sb_latency", 32'(cyc), 32'(e.cyc));
        end
      end
      busy_q = busy;
      done_q = done;
    end
  end

  task automatic wr_word(input int a, input logic [31:0] d);
    prog_we    = 1'b1;
    prog_addr  = a[4:0];
    prog_wdata = d;
    m_mem[a[4:0]] = d;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic load_prog();
    foreach (prog_q[i]) wr_word(i, prog_q[i]);
  endtask

  task automatic start_run(input bit push, input bit do_wr, input int a, input logic [31:0] d);
    exp_t e;
    if (do_wr) begin
      prog_we    = 1'b1;
      prog_addr  = a[4:0];
      prog_wdata = d;
      m_mem[a[4:0]] = d;
    end
    if (push) begin
      run_model(e);
      exp_q.push_back(e);
    end
    start = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    prog_we = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!done) bail("timeout_done");
  endtask

  task automatic run_prog();
    load_prog();
    start_run(1, 0, 0, 32'd0);
    wait_done();
  endtask

  task automatic gen_random();
    int L, ill_at, k, f3, t, rd, rs1, rs2;
    int r_f3[7] = '{0, 1, 2, 4, 5, 6, 7};
    int i_f3[5] = '{0, 2, 4, 6, 7};
    logic [31:0] w;
    prog_q.delete();
    L = $urandom_range(3, 18);
    ill_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, L - 1)) : -1;
    for (int i = 0; i < L; i++) begin
      rd  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
      rs1 = $urandom_range(0, 7);
      rs2 = $urandom_range(0, 7);
      k   = $urandom_range(0, 9);
      if (i == ill_at) begin
        case ($urandom_range(0, 2))
          0:       w = 32'h0000_007F;
          1:       w = enc_b(4, rs2, rs1, int'($urandom_range(2, 7)));
          default: begin w = $urandom(); w[6:0] = 7'h03; end
        endcase
      end else if (k <= 3) begin
        f3 = r_f3[$urandom_range(0, 6)];
        w  = enc_r(((f3 == 0 || f3 == 5) && $urandom_range(0, 1) == 1) ? 32 : 0, rs2, rs1, f3, rd);
      end else if (k <= 6) begin
        w = enc_i(int'($urandom_range(0, 4095)), rs1, i_f3[$urandom_range(0, 4)], rd);
      end else if (k == 7) begin
        w = enc_u(int'($urandom_range(0, 20'hFFFFF)), rd);
      end else begin
        t = $urandom_range(i + 1, L);
        w = enc_b(4 * (t - i), rs2, rs1, int'($urandom_range(0, 1)));
      end
      prog_q.push_back(w);
    end
    prog_q.push_back(ECALL);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=still running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] sp[8];
    int n;
    reset = 1'b0; start = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
    s_start = 1'b0; s_we = 1'b0; s_addr = '0; s_wdata = '0;
    for (int i = 0; i < 32; i++) m_mem[i] = 32'd0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_out_value", out_value, 0);
    chk("rst_retired", 32'(retired), 0);
    reset = 1'b1;
    @(negedge clk);

    prog_q = '{enc_i(5, 0, 0, 1), enc_i(7, 0, 0, 2), enc_r(0, 2, 1, 0, 3), ECALL};
    run_prog();
    chk("basic_out_value", out_value, 32'd12);
    chk("basic_retired", 32'(retired), 32'd3);
    chk("basic_error", 32'(error), 32'd0);

    // Start and a program write while busy must both be dropped.
    start_run(1, 0, 0, 32'd0);
    repeat (5) @(negedge clk);
    start = 1'b1; prog_we = 1'b1; prog_addr = 5'd0; prog_wdata = ECALL;
    @(negedge clk);
    start = 1'b0; prog_we = 1'b0;
    wait_done();
    start_run(1, 0, 0, 32'd0);
    wait_done();
    chk("busy_write_dropped", 32'(retired), 32'd3);

    start_run(1, 1, 0, enc_i(20, 0, 0, 1));
    wait_done();
    chk("start_cycle_write", out_value, 32'd27);

    prog_q = '{enc_i(3, 0, 0, 1), enc_i(12'hFFF, 1, 0, 1), enc_b(-4, 0, 1, 1), ECALL};
    run_prog();
    chk("loop_retired", 32'(retired), 32'd7);
    chk("loop_out_value", out_value, 32'd0);
    chk("loop_pc", 32'(pc), 32'd3);

    prog_q = '{enc_i(1, 0, 0, 1), enc_r(32, 1, 0, 0, 2), ECALL};
    run_prog();
    chk("sub_wrap", out_value, 32'hFFFF_FFFF);
    prog_q = '{enc_u(20'h80000, 3), enc_i(31, 0, 0, 4), enc_r(32, 4, 3, 5, 5), ECALL};
    run_prog();
    chk("sra_31", out_value, 32'hFFFF_FFFF);
    prog_q = '{enc_i(12'hFFF, 0, 0, 6), enc_r(0, 1, 6, 2, 7), enc_i(9, 0, 0, 0), ECALL};
    run_prog();
    chk("slt_x0_write", out_value, 32'd1);
    prog_q = '{enc_r(0, 0, 0, 0, 9), ECALL};
    run_prog();
    chk("x0_reads_zero", out_value, 32'd0);

    prog_q = '{enc_i(1, 0, 0, 1), enc_i(2, 0, 0, 2), 32'h0000_007F};
    run_prog();
    chk("ill_error", 32'(error), 32'd1);
    chk("ill_done", 32'(done), 32'd1);
    chk("ill_pc", 32'(pc), 32'd2);
    chk("ill_retired", 32'(retired), 32'd2);

    repeat (40) begin
      gen_random();
      run_prog();
    end

    // Abort in EXECUTE of the ADD: x3 must never be written.
    prog_q = '{enc_i(5, 0, 0, 1), enc_i(7, 0, 0, 2), enc_r(0, 2, 1, 0, 3), ECALL};
    load_prog();
    start_run(0, 0, 0, 32'd0);
    repeat (10) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_pc", 32'(pc), 0);
    chk("abort_out_value", out_value, 0);
    chk("abort_retired", 32'(retired), 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    prog_q = '{enc_i(1, 3, 0, 5), ECALL};
    run_prog();
    chk("abort_no_write", out_value, 32'd1);

    sp = '{enc_b(8, 0, 5, 0), ECALL, enc_i(9, 0, 0, 17), enc_r(0, 0, 1, 0, 2),
           enc_i(1, 0, 0, 5), enc_r(0, 2, 1, 0, 6), enc_i(3, 0, 0, 0), enc_r(0, 0, 6, 0, 7)};
    for (int i = 0; i < 8; i++) begin
      s_we = 1'b1; s_addr = i[2:0]; s_wdata = sp[i];
      @(negedge clk);
    end
    s_we = 1'b0;
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    n = 0;
    while (!s_done && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!s_done) bail("timeout_small");
    chk("alias_pc", 32'(s_pc), 32'd1);
    chk("alias_retired", 32'(s_ret), 32'd8);
    chk("alias_out_value", s_out, 32'd18);
    chk("alias_error", 32'(s_error), 32'd0);
    chk("alias_busy", 32'(s_busy), 32'd0);

    repeat (2) @(negedge clk);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    summary_and_finish();
  end

endmodule
